// File: rtl/algo_2r1w_b80_meminit_if.sv
// Bank-port bundle shared by the core side and the T1 SRAM side of the init stage.
// The master drives the request signals and the slave returns the read data.
interface algo_2r1w_b80_meminit_if #(
   parameter int N       = 8,
   parameter int BITSROW = 12,
   parameter int PHYWDTH = 128
);
   logic [N-1:0]         writeA;
   logic [N*BITSROW-1:0] addrA;
   logic [N*PHYWDTH-1:0] dinA;
   logic [N*PHYWDTH-1:0] bwA;
   logic [N-1:0]         readB;
   logic [N*BITSROW-1:0] addrB;
   logic [N*PHYWDTH-1:0] doutB;

   modport master (output writeA, addrA, dinA, bwA, readB, addrB, input doutB);
   modport slave  (input writeA, addrA, dinA, bwA, readB, addrB, output doutB);
endinterface

// File: rtl/algo_2r1w_b80_meminit.sv
// Sweeps every T1 bank row with INITVAL after reset or reinit, then steers core
// port A/B traffic straight through to the T1 SRAMs while ready is high.
//
// state | meaning
// IDLE  | post-reset, all T1 enables low
// INIT  | writing INITVAL to row_q of every bank
// DRAIN | waiting SRAM_DELAY cycles for in-flight reads to settle
// DONE  | passthrough, ready high
module algo_2r1w_b80_meminit #(
   parameter int NUMRDPT    = 2,
   parameter int NUMVBNK    = 4,
   parameter int NUMSROW    = 4096,
   parameter int BITSROW    = 12,
   parameter int PHYWDTH    = 128,
   parameter int SRAM_DELAY = 1,
   parameter logic [PHYWDTH-1:0] INITVAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic reinit,
   output logic ready,
   algo_2r1w_b80_meminit_if.slave  a,
   algo_2r1w_b80_meminit_if.master t1
);
   localparam int N = NUMRDPT * NUMVBNK;
   localparam logic [BITSROW-1:0] LAST_ROW  = BITSROW'(NUMSROW - 1);
   localparam logic [2:0]         DRAIN_TOP = 3'(SRAM_DELAY - 1);

   typedef enum logic [1:0] {IDLE, INIT, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [BITSROW-1:0] row_q, row_d;
   logic [2:0]         drain_q, drain_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      drain_d    = drain_q;
      ready      = 1'b0;
      t1.writeA  = '0;
      t1.addrA   = '0;
      t1.dinA    = '0;
      t1.bwA     = '0;
      t1.readB   = '0;
      t1.addrB   = '0;
      unique case (state_q)
         IDLE: begin
            state_d = INIT;
            row_d   = '0;
         end
         INIT: begin
            t1.writeA = '1;
            t1.addrA  = {N{row_q}};
            t1.dinA   = {N{INITVAL}};
            t1.bwA    = '1;
            if (row_q == LAST_ROW) begin
               row_d   = '0;
               drain_d = DRAIN_TOP;
               state_d = (SRAM_DELAY == 0) ? DONE : DRAIN;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         DRAIN: begin
            // Down-counter loaded with SRAM_DELAY-1 on entry; terminal count exits.
            if (drain_q == 3'd0) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         DONE: begin
            ready     = 1'b1;
            t1.writeA = a.writeA;
            t1.addrA  = a.addrA;
            t1.dinA   = a.dinA;
            t1.bwA    = a.bwA;
            t1.readB  = a.readB;
            t1.addrB  = a.addrB;
            if (reinit) begin
               state_d = INIT;
               row_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data returns with the SRAM's own latency; no retiming here.
   assign a.doutB = t1.doutB;

endmodule
